// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the register bank write controller.
package reg_bank_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      CLEAR = 2'd2
   } state_t;

   function automatic int addr_width(input int depth);
      int w;
      if (depth > 1) begin
         w = $clog2(depth);
      end else begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/reg_bank_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last granted requester.
module rr_arbiter
   import reg_bank_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int IW   = addr_width(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last_grant,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   grant_idx
);

   logic [IW:0] cand_s;
   logic [IW:0] idx_s;
   logic        found_s;

   // Walk the requesters in rotated priority order, take the first active one.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found_s   = 1'b0;
      cand_s    = '0;
      idx_s     = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand_s = {1'b0, last_grant} + (IW+1)'(k);
         if (cand_s >= (IW+1)'(NREQ)) begin
            idx_s = cand_s - (IW+1)'(NREQ);
         end else begin
            idx_s = cand_s;
         end
         if (!found_s && req[idx_s[IW-1:0]]) begin
            found_s                 = 1'b1;
            grant[idx_s[IW-1:0]]    = 1'b1;
            grant_idx               = idx_s[IW-1:0];
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/reg_bank_ctrl.sv
// Write controller for a small register bank: round-robin shared write port,
// sequenced clear and a combinational read port.
module reg_bank_ctrl
   import reg_bank_pkg::*;
#(
   parameter  int WIDTH = 4,
   parameter  int DEPTH = 4,
   parameter  int NREQ  = 3,
   localparam int AW    = addr_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*AW-1:0]    req_addr,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic                  wr_err,
   input  logic                  clr_req,
   output logic                  clr_done,
   output logic                  busy,
   input  logic [AW-1:0]         rd_addr,
   output logic [WIDTH-1:0]      rd_data
);

   localparam int IW = addr_width(NREQ);

   state_t            state_r;
   logic [WIDTH-1:0]  bank_r [DEPTH];
   logic [IW-1:0]     win_id_r;
   logic [AW-1:0]     addr_r;
   logic [WIDTH-1:0]  data_r;
   logic [IW-1:0]     last_grant_r;
   logic [AW-1:0]     clr_cnt_r;

   logic [NREQ-1:0]   grant_s;
   logic [IW-1:0]     grant_idx_s;
   logic [AW-1:0]     sel_addr_s;
   logic [WIDTH-1:0]  sel_data_s;
   logic              wr_in_range_s;

   rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_arb (
      .req        (req_valid),
      .last_grant (last_grant_r),
      .grant      (grant_s),
      .grant_idx  (grant_idx_s)
   );

   // One-hot AND-OR mux picking the winning requester's address and data.
   always_comb begin
      sel_addr_s = '0;
      sel_data_s = '0;
      for (int i = 0; i < NREQ; i++) begin
         sel_addr_s = sel_addr_s | (req_addr[i*AW +: AW] & {AW{grant_s[i]}});
         sel_data_s = sel_data_s | (req_data[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
      end
   end

   assign wr_in_range_s = (32'(addr_r) < DEPTH);

   // FSM, holding registers and bank storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         bank_r       <= '{default: '0};
         win_id_r     <= '0;
         addr_r       <= '0;
         data_r       <= '0;
         last_grant_r <= IW'(NREQ-1);
         clr_cnt_r    <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (clr_req) begin
                  state_r   <= CLEAR;
                  clr_cnt_r <= '0;
               end else if (|req_valid) begin
                  win_id_r <= grant_idx_s;
                  addr_r   <= sel_addr_s;
                  data_r   <= sel_data_s;
                  state_r  <= WRITE;
               end else begin
                  state_r <= IDLE;
               end
            end
            WRITE: begin
               if (wr_in_range_s) begin
                  bank_r[addr_r] <= data_r;
               end
               last_grant_r <= win_id_r;
               state_r      <= IDLE;
            end
            CLEAR: begin
               bank_r[clr_cnt_r] <= '0;
               if (clr_cnt_r == AW'(DEPTH-1)) begin
                  clr_cnt_r <= '0;
                  state_r   <= IDLE;
               end else begin
                  clr_cnt_r <= clr_cnt_r + AW'(1);
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   // Outputs decode registered state only; rd_data is the combinational read port.
   always_comb begin
      busy     = (state_r != IDLE);
      clr_done = (state_r == CLEAR) && (clr_cnt_r == AW'(DEPTH-1));
      if (state_r == WRITE) begin
         req_ready = NREQ'(1'b1) << win_id_r;
         wr_err    = !wr_in_range_s;
      end else begin
         req_ready = '0;
         wr_err    = 1'b0;
      end
      if (32'(rd_addr) < DEPTH) begin
         rd_data = bank_r[rd_addr];
      end else begin
         rd_data = '0;
      end
   end

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Directed bench: a per-cycle vector table on the default build plus a short
// hand-written sequence on a DEPTH=3 build for out-of-range writes.
module tb_reg_bank_ctrl;

   typedef struct {
      logic        rst;
      logic        clr;
      logic [2:0]  valid;
      logic [5:0]  addr;
      logic [11:0] data;
      logic [1:0]  rd_addr;
      logic        chk;
      logic [2:0]  exp_ready;
      logic        exp_err;
      logic        exp_done;
      logic        exp_busy;
      logic [3:0]  exp_rd;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_bad = 0;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  valid, ready, d3_valid, d3_ready;
   logic [5:0]  addr, d3_addr;
   logic [11:0] data, d3_data;
   logic        clr, err, done, busy;
   logic        d3_err, d3_done, d3_busy;
   logic [1:0]  rd_addr, d3_rd_addr;
   logic [3:0]  rd_data, d3_rd_data;

   always #5 clk = ~clk;

   reg_bank_ctrl dut (
      .clk(clk), .rst(rst), .req_valid(valid), .req_addr(addr), .req_data(data),
      .req_ready(ready), .wr_err(err), .clr_req(clr), .clr_done(done), .busy(busy),
      .rd_addr(rd_addr), .rd_data(rd_data)
   );

   reg_bank_ctrl #(.WIDTH(4), .DEPTH(3), .NREQ(3)) dut3 (
      .clk(clk), .rst(rst), .req_valid(d3_valid), .req_addr(d3_addr), .req_data(d3_data),
      .req_ready(d3_ready), .wr_err(d3_err), .clr_req(1'b0), .clr_done(d3_done), .busy(d3_busy),
      .rd_addr(d3_rd_addr), .rd_data(d3_rd_data)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic r, input logic c, input logic [2:0] v, input logic [5:0] a,
                      input logic [11:0] d, input logic [1:0] ra, input logic ck,
                      input logic [2:0] er, input logic ee, input logic ed, input logic eb,
                      input logic [3:0] erd);
      vecs.push_back('{r, c, v, a, d, ra, ck, er, ee, ed, eb, erd});
   endtask

   task automatic chk3(input string nm, input logic [2:0] er, input logic ee, input logic [3:0] erd);
      #1;
      n_vec++;
      if (d3_ready !== er || d3_err !== ee || d3_rd_data !== erd) begin
         n_bad++;
         $display("FAIL %s: ready=%b wr_err=%b rd_data=%h, expected ready=%b wr_err=%b rd_data=%h",
                  nm, d3_ready, d3_err, d3_rd_data, er, ee, erd);
      end
   endtask

   initial begin
      // Single write: requester 1, addr 2, data 0xA
      add(0,0,3'b000,6'h00,12'h000,2'd0,1, 3'b000,0,0,0,4'h0);
      add(0,0,3'b010,6'h08,12'h0A0,2'd2,1, 3'b000,0,0,0,4'h0);
      add(0,0,3'b010,6'h08,12'h0A0,2'd2,1, 3'b010,0,0,1,4'h0);
      add(0,0,3'b000,6'h00,12'h000,2'd2,1, 3'b000,0,0,0,4'hA);
      add(0,0,3'b000,6'h00,12'h000,2'd0,1, 3'b000,0,0,0,4'h0);
      add(0,0,3'b000,6'h00,12'h000,2'd1,1, 3'b000,0,0,0,4'h0);
      add(0,0,3'b000,6'h00,12'h000,2'd3,1, 3'b000,0,0,0,4'h0);
      add(1,0,3'b000,6'h00,12'h000,2'd0,0, 3'b000,0,0,0,4'h0);
      // Round-robin: req i writes addr i with data i+1
      add(0,0,3'b111,6'h24,12'h321,2'd2,1, 3'b000,0,0,0,4'h0);
      add(0,0,3'b111,6'h24,12'h321,2'd0,1, 3'b001,0,0,1,4'h0);
      add(0,0,3'b111,6'h24,12'h321,2'd0,1, 3'b000,0,0,0,4'h1);
      add(0,0,3'b111,6'h24,12'h321,2'd1,1, 3'b010,0,0,1,4'h0);
      add(0,0,3'b111,6'h24,12'h321,2'd1,1, 3'b000,0,0,0,4'h2);
      add(0,0,3'b111,6'h24,12'h321,2'd2,1, 3'b100,0,0,1,4'h0);
      add(0,0,3'b111,6'h24,12'h321,2'd2,1, 3'b000,0,0,0,4'h3);
      add(0,0,3'b111,6'h24,12'h321,2'd0,1, 3'b001,0,0,1,4'h1);
      add(0,0,3'b111,6'h24,12'h321,2'd0,1, 3'b000,0,0,0,4'h1);
      add(0,0,3'b111,6'h24,12'h321,2'd1,1, 3'b010,0,0,1,4'h2);
      add(0,0,3'b111,6'h24,12'h321,2'd1,1, 3'b000,0,0,0,4'h2);
      add(0,0,3'b111,6'h24,12'h321,2'd2,1, 3'b100,0,0,1,4'h3);
      add(0,0,3'b000,6'h00,12'h000,2'd3,1, 3'b000,0,0,0,4'h0);
      // Preload addr 3 = 4 so the bank holds 1,2,3,4
      add(0,0,3'b001,6'h03,12'h004,2'd3,1, 3'b000,0,0,0,4'h0);
      add(0,0,3'b001,6'h03,12'h004,2'd3,1, 3'b001,0,0,1,4'h0);
      add(0,0,3'b000,6'h00,12'h000,2'd3,1, 3'b000,0,0,0,4'h4);
      // Clear beats requester 0 (addr 1, data 0xF); requester acked 2 cycles after clr_done
      add(0,1,3'b001,6'h01,12'h00F,2'd1,1, 3'b000,0,0,0,4'h2);
      add(0,0,3'b001,6'h01,12'h00F,2'd0,1, 3'b000,0,0,1,4'h1);
      add(0,0,3'b001,6'h01,12'h00F,2'd0,1, 3'b000,0,0,1,4'h0);
      add(0,0,3'b001,6'h01,12'h00F,2'd1,1, 3'b000,0,0,1,4'h0);
      add(0,0,3'b001,6'h01,12'h00F,2'd3,1, 3'b000,0,1,1,4'h4);
      add(0,0,3'b001,6'h01,12'h00F,2'd2,1, 3'b000,0,0,0,4'h0);
      add(0,0,3'b001,6'h01,12'h00F,2'd3,1, 3'b001,0,0,1,4'h0);
      add(0,0,3'b000,6'h00,12'h000,2'd1,1, 3'b000,0,0,0,4'hF);
      // Reset during CLEAR at clr_cnt=1
      add(0,1,3'b000,6'h00,12'h000,2'd1,1, 3'b000,0,0,0,4'hF);
      add(0,0,3'b000,6'h00,12'h000,2'd1,1, 3'b000,0,0,1,4'hF);
      add(1,0,3'b000,6'h00,12'h000,2'd1,1, 3'b000,0,0,1,4'hF);
      add(0,0,3'b000,6'h00,12'h000,2'd1,1, 3'b000,0,0,0,4'h0);
      add(0,0,3'b000,6'h00,12'h000,2'd3,1, 3'b000,0,0,0,4'h0);
      // Reset during WRITE: requester 2 writes addr 2 data 5, write discarded
      add(0,0,3'b100,6'h20,12'h500,2'd2,1, 3'b000,0,0,0,4'h0);
      add(1,0,3'b100,6'h20,12'h500,2'd2,0, 3'b000,0,0,0,4'h0);
      add(0,0,3'b000,6'h00,12'h000,2'd2,1, 3'b000,0,0,0,4'h0);
      add(0,0,3'b000,6'h00,12'h000,2'd0,1, 3'b000,0,0,0,4'h0);
      add(0,0,3'b000,6'h00,12'h000,2'd1,1, 3'b000,0,0,0,4'h0);
      add(0,0,3'b000,6'h00,12'h000,2'd3,1, 3'b000,0,0,0,4'h0);
      // Preload addr 3 = 9 via requester 1, then hold clr_req for two cycles past clr_done
      add(0,0,3'b010,6'h0C,12'h090,2'd3,1, 3'b000,0,0,0,4'h0);
      add(0,0,3'b010,6'h0C,12'h090,2'd3,1, 3'b010,0,0,1,4'h0);
      add(0,0,3'b000,6'h00,12'h000,2'd3,1, 3'b000,0,0,0,4'h9);
      add(0,1,3'b000,6'h00,12'h000,2'd3,1, 3'b000,0,0,0,4'h9);
      add(0,1,3'b000,6'h00,12'h000,2'd3,1, 3'b000,0,0,1,4'h9);
      add(0,1,3'b000,6'h00,12'h000,2'd3,1, 3'b000,0,0,1,4'h9);
      add(0,1,3'b000,6'h00,12'h000,2'd3,1, 3'b000,0,0,1,4'h9);
      add(0,1,3'b000,6'h00,12'h000,2'd3,1, 3'b000,0,1,1,4'h9);
      add(0,1,3'b000,6'h00,12'h000,2'd3,1, 3'b000,0,0,0,4'h0);
      add(0,1,3'b000,6'h00,12'h000,2'd3,1, 3'b000,0,0,1,4'h0);
      add(0,0,3'b000,6'h00,12'h000,2'd3,1, 3'b000,0,0,1,4'h0);
      add(0,0,3'b000,6'h00,12'h000,2'd3,1, 3'b000,0,0,1,4'h0);
      add(0,0,3'b000,6'h00,12'h000,2'd3,1, 3'b000,0,1,1,4'h0);
      add(0,0,3'b000,6'h00,12'h000,2'd3,1, 3'b000,0,0,0,4'h0);
      add(0,0,3'b000,6'h00,12'h000,2'd3,1, 3'b000,0,0,0,4'h0);

      rst = 1'b1; clr = 1'b0; valid = '0; addr = '0; data = '0; rd_addr = '0;
      d3_valid = '0; d3_addr = '0; d3_data = '0; d3_rd_addr = '0;
      tick();
      tick();
      rst = 1'b0;

      // DEPTH=3 build: valid write, out-of-range write, dropped-valid write
      d3_valid = 3'b001; d3_addr = 6'h02; d3_data = 12'h007; d3_rd_addr = 2'd2;
      chk3("d3_idle", 3'b000, 1'b0, 4'h0);
      tick();
      d3_addr = 6'h03; d3_data = 12'h00C;
      chk3("d3_wr_ok", 3'b001, 1'b0, 4'h0);
      tick();
      chk3("d3_rd_after_wr", 3'b000, 1'b0, 4'h7);
      tick();
      d3_valid = 3'b000; d3_rd_addr = 2'd3;
      chk3("d3_oor_ack_err", 3'b001, 1'b1, 4'h0);
      tick();
      d3_rd_addr = 2'd2;
      d3_valid = 3'b010; d3_addr = 6'h04; d3_data = 12'h060;
      chk3("d3_bank_kept", 3'b000, 1'b0, 4'h7);
      tick();
      d3_valid = 3'b000; d3_rd_addr = 2'd1;
      chk3("d3_dropped_valid_acked", 3'b010, 1'b0, 4'h0);
      tick();
      chk3("d3_dropped_valid_write", 3'b000, 1'b0, 4'h6);
      d3_rd_addr = 2'd3;
      chk3("d3_rd_oor_zero", 3'b000, 1'b0, 4'h0);
      tick();

      foreach (vecs[i]) begin
         rst = vecs[i].rst; clr = vecs[i].clr; valid = vecs[i].valid;
         addr = vecs[i].addr; data = vecs[i].data; rd_addr = vecs[i].rd_addr;
         #1;
         if (vecs[i].chk) begin
            n_vec++;
            if (ready !== vecs[i].exp_ready || err !== vecs[i].exp_err || done !== vecs[i].exp_done ||
                busy !== vecs[i].exp_busy || rd_data !== vecs[i].exp_rd) begin
               n_bad++;
               $display("FAIL row %0d: ready=%b wr_err=%b clr_done=%b busy=%b rd_data=%h, expected ready=%b wr_err=%b clr_done=%b busy=%b rd_data=%h",
                        i, ready, err, done, busy, rd_data, vecs[i].exp_ready, vecs[i].exp_err,
                        vecs[i].exp_done, vecs[i].exp_busy, vecs[i].exp_rd);
            end
         end
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
